// File: rtl/systolic_result_drain_if.sv
// Result stream between the systolic drain block and the downstream result sink.
// The drain side drives word, index and framing; the sink answers with ready.
interface systolic_result_drain_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Result-side reader for the 3x3 systolic MAC array. A pass starts with the
// first input beat. The block waits out the input skew, snapshots every
// accumulator in one cycle and clears the MACs. It then streams the nine
// results out over a valid/ready handshake.
module systolic_result_drain #(
    parameter int DATA_W   = 64,
    parameter int N_ELEM   = 9,
    parameter int K_DEPTH  = 3,
    parameter int SKEW_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_ELEM*DATA_W-1:0] acc_in,
    output logic                     acc_clr,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    systolic_result_drain_if.master  out_if
);

    localparam int PASS_LEN = K_DEPTH + SKEW_LAT;
    localparam int CNT_W    = $clog2(PASS_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASS_LEN - 1);
    localparam logic [3:0]       IDX_LAST = 4'(N_ELEM - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic               acc_clr_d, done_d, overrun_d;
    logic               capture;
    logic [DATA_W-1:0]  shadow_q [N_ELEM];

    // State, counters and the one-cycle pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_clr <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_clr <= acc_clr_d;
            done    <= done_d;
            overrun <= overrun_d;
        end
    end

    // Pass sequencing: count out the skew, capture, then advance on each accepted word
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        acc_clr_d = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    capture   = 1'b1;
                    acc_clr_d = 1'b1;
                    idx_d     = '0;
                    state_d   = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (out_if.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow copy of the array outputs, taken only on the capture edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N_ELEM; i++) begin
                shadow_q[i] <= acc_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stream outputs are decoded from state so they hold steady under back-pressure
    always_comb begin
        busy             = (state_q != IDLE);
        out_if.out_valid = (state_q == DRAIN);
        out_if.out_idx   = idx_q;
        out_if.out_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
        out_if.out_data  = (state_q == DRAIN) ? shadow_q[idx_q] : '0;
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain. Each pass is described by a
// table row. The expected stream is the snapshot of acc_in that the bench
// drove at the capture edge, which falls K_DEPTH+SKEW_LAT edges after start.
module tb_systolic_result_drain;

    localparam int DATA_W   = 64;
    localparam int N_ELEM   = 9;
    localparam int K_DEPTH  = 3;
    localparam int SKEW_LAT = 4;
    localparam int PASS_LEN = K_DEPTH + SKEW_LAT;
    localparam int BUDGET   = 200;

    typedef struct {
        logic        fixed_data;
        logic        rand_ready;
        logic [15:0] ready_mask;
        logic        glitch;
        logic        start_accum;
        logic        start_drain;
        logic        b2b_next;
        logic        exp_overrun;
    } pass_vec_t;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [N_ELEM*DATA_W-1:0] acc_in;
    logic                     acc_clr;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_data [N_ELEM];
    pass_vec_t         vecs [8];

    systolic_result_drain_if #(.DATA_W(DATA_W)) bus ();

    systolic_result_drain #(
        .DATA_W  (DATA_W),
        .N_ELEM  (N_ELEM),
        .K_DEPTH (K_DEPTH),
        .SKEW_LAT(SKEW_LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .acc_in (acc_in),
        .acc_clr(acc_clr),
        .busy   (busy),
        .done   (done),
        .overrun(overrun),
        .out_if (bus.master)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded loops
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},  64'(busy), 64'd0);
        checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_last"},  64'(bus.out_last), 64'd0);
        checkOutput({tag, "_idx"},   64'(bus.out_idx), 64'd0);
        checkOutput({tag, "_data"},  bus.out_data, 64'd0);
        checkOutput({tag, "_clr"},   64'(acc_clr), 64'd0);
    endtask

    // One full pass: start, skew wait, capture, drain, completion
    task automatic applyStimulus(input pass_vec_t v, input int row);
        logic quiet;
        logic clr_quiet;
        logic ready;
        int   beats;
        int   cycles;
        string tag;
        tag = $sformatf("row%0d", row);

        for (int i = 0; i < N_ELEM; i++) begin
            exp_data[i] = v.fixed_data ? (64'h1000_0000_0000_0000 + 64'(i))
                                       : {$urandom, $urandom};
            acc_in[i*DATA_W +: DATA_W] = exp_data[i];
        end

        start = 1'b1;
        step();
        start = 1'b0;

        quiet = 1'b1;
        for (int c = 1; c <= PASS_LEN; c++) begin
            start = v.start_accum && (c == 3);
            step();
            start = 1'b0;
            if (c < PASS_LEN) begin
                if (bus.out_valid || acc_clr || !busy) quiet = 1'b0;
            end
        end
        checkOutput({tag, "_preCaptureQuiet"}, 64'(quiet), 64'd1);
        checkOutput({tag, "_clrAtCapture"}, 64'(acc_clr), 64'd1);
        checkOutput({tag, "_validAtCapture"}, 64'(bus.out_valid), 64'd1);

        if (v.glitch) begin
            for (int i = 0; i < N_ELEM; i++) begin
                acc_in[i*DATA_W +: DATA_W] = 64'hDEAD_BEEF_0000_0000;
            end
        end

        beats     = 0;
        cycles    = 0;
        clr_quiet = 1'b1;
        while (beats < N_ELEM && cycles < BUDGET) begin
            checkOutput({tag, "_drainValid"}, 64'(bus.out_valid), 64'd1);
            checkOutput({tag, "_drainIdx"}, 64'(bus.out_idx), 64'(beats));
            checkOutput({tag, "_drainData"}, bus.out_data, exp_data[beats]);
            checkOutput({tag, "_drainLast"}, 64'(bus.out_last), 64'(beats == N_ELEM - 1));
            ready = v.rand_ready ? 1'($urandom_range(0, 1)) : v.ready_mask[cycles % 16];
            bus.out_ready = ready;
            start = v.start_drain && (cycles == 2);
            step();
            start = 1'b0;
            if (acc_clr) clr_quiet = 1'b0;
            if (ready) beats++;
            cycles++;
        end
        bus.out_ready = 1'b0;
        checkOutput({tag, "_drainBeats"}, 64'(beats), 64'(N_ELEM));
        checkOutput({tag, "_clrOneCycle"}, 64'(clr_quiet), 64'd1);
        if (!v.rand_ready && v.ready_mask == 16'hFFFF) begin
            checkOutput({tag, "_throughput"}, 64'(cycles), 64'(N_ELEM));
        end

        checkOutput({tag, "_donePulse"}, 64'(done), 64'd1);
        checkIdleOutputs({tag, "_end"});
        checkOutput({tag, "_overrun"}, 64'(overrun), 64'(v.exp_overrun));

        if (!v.b2b_next) begin
            step();
            checkOutput({tag, "_doneCleared"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst           = 1'b0;
        start         = 1'b0;
        acc_in        = '0;
        bus.out_ready = 1'b0;
        #2;
        checkIdleOutputs("reset");
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_overrun", 64'(overrun), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        step();

        for (int r = 0; r < 7; r++) begin
            applyStimulus(vecs[r], r);
        end

        // Reset in the middle of a drain, after four words have gone out
        for (int i = 0; i < N_ELEM; i++) begin
            acc_in[i*DATA_W +: DATA_W] = 64'h2000_0000_0000_0000 + 64'(i);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (PASS_LEN) step();
        bus.out_ready = 1'b1;
        repeat (4) step();
        checkOutput("midDrain_idx", 64'(bus.out_idx), 64'd4);
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkIdleOutputs("asyncReset");
        checkOutput("asyncReset_done", 64'(done), 64'd0);
        checkOutput("asyncReset_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        checkIdleOutputs("postReset");

        applyStimulus(vecs[7], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
